// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, a, b, input busy, done, d, bout);
  modport slave  (input start, a, b, output busy, done, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial D = A - B, LSB first, one borrow step per clock
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  logic             load, step, last;
  logic             a_bit, b_bit, diff_bit, br_next;
  logic [WIDTH:0]   sr_cat;
  logic [WIDTH-1:0] sr_shift;

  assign last     = (cnt == CW'(WIDTH - 1));
  assign a_bit    = sa[0];
  assign b_bit    = sb[0];
  assign diff_bit = a_bit ^ b_bit ^ br;
  assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  // Concatenate-then-slice keeps the shift legal when WIDTH is 1.
  assign sr_cat   = {diff_bit, sr};
  assign sr_shift = sr_cat[WIDTH:1];

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = FIN;
        end
      end
      FIN: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        sa  <= bus.a;
        sb  <= bus.b;
        br  <= 1'b0;
        cnt <= '0;
      end else if (step) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sr  <= sr_shift;
        br  <= br_next;
        cnt <= cnt + 1'b1;
        // Results only move on the edge entering FIN so they hold through the next run.
        if (last) begin
          d_q    <= sr_shift;
          bout_q <= br_next;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - random and directed checks of serial_subtractor at WIDTH 8 and 1
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an operation accepted on edge e is busy after edges e..e+W-1, done after e+W.
  int          age[2]     = '{-1, -1};
  int          accepts[2] = '{0, 0};
  logic [7:0]  pend_d[2], exp_d[2];
  logic        pend_b[2], exp_b[2];

  always @(posedge clk) begin
    int         w;
    logic       s;
    logic [7:0] av, bv, m;
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 8 : 1;
      m  = (k == 0) ? 8'hFF : 8'h01;
      s  = (k == 0) ? bus8.start : bus1.start;
      av = (k == 0) ? bus8.a : {7'b0, bus1.a};
      bv = (k == 0) ? bus8.b : {7'b0, bus1.b};
      if (!rst_n) begin
        age[k]   = -1;
        exp_d[k] = 8'h00;
        exp_b[k] = 1'b0;
      end else if ((age[k] == -1 || age[k] == w) && s) begin
        age[k]    = 0;
        pend_d[k] = (av - bv) & m;
        pend_b[k] = (av < bv);
        accepts[k]++;
      end else if (age[k] >= 0) begin
        age[k]++;
        if (age[k] > w) age[k] = -1;
      end
      if (age[k] == w) begin
        exp_d[k] = pend_d[k];
        exp_b[k] = pend_b[k];
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("w8 busy", {31'b0, bus8.busy}, {31'b0, (age[0] >= 0 && age[0] < 8)});
      check("w8 done", {31'b0, bus8.done}, {31'b0, (age[0] == 8)});
      check("w8 d",    {24'b0, bus8.d},    {24'b0, exp_d[0]});
      check("w8 bout", {31'b0, bus8.bout}, {31'b0, exp_b[0]});
      check("w1 busy", {31'b0, bus1.busy}, {31'b0, (age[1] == 0)});
      check("w1 done", {31'b0, bus1.done}, {31'b0, (age[1] == 1)});
      check("w1 d",    {31'b0, bus1.d},    {31'b0, exp_d[1][0]});
      check("w1 bout", {31'b0, bus1.bout}, {31'b0, exp_b[1]});
    end
  end

  task automatic wait_done8(input string nm);
    int g = 0;
    while (!bus8.done && g < 30) begin
      @(negedge clk);
      g++;
    end
    check({nm, " done seen"}, {31'b0, bus8.done}, 32'd1);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input string nm);
    int bc = 0;
    int g  = 0;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = av;
    bus8.b = bv;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    while (!bus8.done && g < 30) begin
      if (bus8.busy) bc++;
      @(negedge clk);
      g++;
    end
    check({nm, " done seen"},   {31'b0, bus8.done}, 32'd1);
    check({nm, " busy cycles"}, bc, 32'd8);
    check({nm, " d"},           {24'b0, bus8.d}, {24'b0, ed});
    check({nm, " bout"},        {31'b0, bus8.bout}, {31'b0, eb});
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    check("reset busy", {31'b0, bus8.busy}, 32'd0);
    check("reset done", {31'b0, bus8.done}, 32'd0);
    check("reset d",    {24'b0, bus8.d},    32'd0);
    check("reset bout", {31'b0, bus8.bout}, 32'd0);

    op8(8'd9,   8'd5,   8'h04, 1'b0, "9-5");
    op8(8'd5,   8'd9,   8'hFC, 1'b1, "5-9");
    op8(8'h00,  8'h00,  8'h00, 1'b0, "0-0");
    op8(8'hFF,  8'hFF,  8'h00, 1'b0, "FF-FF");
    op8(8'h00,  8'hFF,  8'h01, 1'b1, "0-FF");

    // START held: A changes in the 4th busy cycle and is picked up by the relaunch from FIN.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd1;
    repeat (4) @(negedge clk);
    bus8.a = 8'h80;
    wait_done8("held first");
    check("held first d",    {24'b0, bus8.d},    32'h02);
    check("held first bout", {31'b0, bus8.bout}, 32'd0);
    @(negedge clk);
    check("held relaunch busy", {31'b0, bus8.busy}, 32'd1);
    bus8.start = 1'b0;
    wait_done8("held second");
    check("held second d",    {24'b0, bus8.d},    32'h7F);
    check("held second bout", {31'b0, bus8.bout}, 32'd0);

    // Reset during the 5th run cycle aborts the operation.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd77; bus8.b = 8'd12;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", {31'b0, bus8.busy}, 32'd0);
    check("abort d",    {24'b0, bus8.d},    32'd0);
    check("abort bout", {31'b0, bus8.bout}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("abort no done", {31'b0, bus8.done}, 32'd0);
      @(negedge clk);
    end
    op8(8'd200, 8'd100, 8'd100, 1'b0, "200-100");

    @(negedge clk);
    accepts[0] = 0;
    accepts[1] = 0;
    n = 0;
    while ((accepts[0] < 1000 || accepts[1] < 1000) && n < 40000) begin
      bus8.start = ($urandom_range(0, 3) != 0);
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      bus1.start = ($urandom_range(0, 3) != 0);
      bus1.a = 1'($urandom);
      bus1.b = 1'($urandom);
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    check("w8 random ops reached", {31'b0, (accepts[0] >= 1000)}, 32'd1);
    check("w1 random ops reached", {31'b0, (accepts[1] >= 1000)}, 32'd1);
    repeat (12) @(negedge clk);
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
